// File: rtl/eth_recv_pkg.sv
//==============================================================================
// eth_recv_pkg -- shared header layout, parser state type and helper functions
// Revision: 1.0
//==============================================================================
`default_nettype none

package eth_recv_pkg;

    localparam logic [15:0] c_ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  c_IPPROTO_UDP    = 8'd17;
    localparam logic [16:0] c_ETH_HLEN       = 17'd14;
    localparam logic [16:0] c_MIN_FRAME      = 17'd60;
    localparam logic [2:0]  c_HDR_LAST_BEAT  = 3'd5;
    localparam logic [3:0]  c_RUNT_LAST_BYTES = 4'd6;

    typedef enum logic [0:0] {
        RX_HDR  = 1'b0,
        RX_BODY = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ethertype;
    } ethhdr_t;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] tot_len;
        logic [15:0] id;
        logic [15:0] frag_off;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] check;
        logic [31:0] saddr;
        logic [31:0] daddr;
    } iphdr_t;

    typedef struct packed {
        logic [15:0] source;
        logic [15:0] dest;
        logic [15:0] len;
        logic [15:0] check;
    } udphdr_t;

    typedef struct packed {
        logic [15:0] id;
        logic        qr;
        logic [3:0]  opcode;
        logic        aa;
        logic        tc;
        logic        rd;
        logic        ra;
        logic [2:0]  z;
        logic [3:0]  rcode;
    } dnshdr_t;

    typedef struct packed {
        ethhdr_t     eth;
        iphdr_t      ip;
        udphdr_t     udp;
        dnshdr_t     dns;
        logic [15:0] pad;
    } pkt_hdr_t;

    // Beat 0 occupies the most significant 64 bits so byte offsets read MSB-first.
    typedef union packed {
        logic [0:5][63:0] beat;
        pkt_hdr_t         h;
    } hdr_u;

    function automatic logic [63:0] endian_conv64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_recv_ip_csum_chk.sv
//==============================================================================
// ip_csum_chk -- incremental one's-complement IPv4 header checksum accumulator
// Revision: 1.0
//==============================================================================
`default_nettype none

module ip_csum_chk (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic [3:0]  i_add,
    input  logic [63:0] i_words,
    output logic        o_ok
);

    // Ten 16-bit words never exceed 20 bits, so carries are folded only at the end.
    logic [19:0] r_acc;
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    always_comb begin
        w_sum = r_acc;
        for (int i = 0; i < 4; i++) begin
            if (i_add[i]) begin
                w_sum = w_sum + {4'h0, i_words[16*i +: 16]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    assign w_fold1 = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};
    assign o_ok    = (w_fold2 == 16'hFFFF);

endmodule

`default_nettype wire

// File: rtl/eth_recv.sv
//==============================================================================
// eth_recv -- DNS-response receive parser, classifier and statistics counters.
// Optional per-frame summary outputs built when ETH_RECV_SUMMARY_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module eth_recv
    import eth_recv_pkg::*;
#(
    parameter logic [31:0] IP_DADDR  = 32'h0A000001,
    parameter logic [15:0] UDP_SPORT = 16'd53,
    parameter logic [15:0] DPORT_LO  = 16'd50001,
    parameter logic [15:0] DPORT_HI  = 16'd51000
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        m_axis_rx_tvalid,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tuser,
    input  logic        cnt_clr,
    output logic [31:0] rx_pkt_cnt,
    output logic [31:0] rx_dns_cnt,
    output logic [31:0] rx_err_cnt,
    output logic [47:0] rx_byte_cnt,
    output logic        pkt_valid,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [31:0] pkt_saddr,
    output logic [15:0] pkt_dport,
    output logic [15:0] pkt_len
);

    rx_state_t   r_state;
    logic [2:0]  r_beat;
    logic [15:0] r_len;
    hdr_u        r_hdr;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_dns_cnt;
    logic [31:0] r_err_cnt;
    logic [47:0] r_byte_cnt;

    logic [63:0] w_data_be;
    logic        w_in_hdr;
    logic        w_end;
    logic [3:0]  w_keep_cnt;
    logic [16:0] w_len_sum;
    logic [15:0] w_len;
    hdr_u        w_hdr;
    logic [3:0]  w_csum_add;
    logic        w_csum_ok;
    logic        w_runt;
    logic [16:0] w_exp_len;
    logic        w_len_ok;
    logic        w_err;
    logic        w_match;
    logic        w_unused_hdr;

    assign w_data_be  = endian_conv64(m_axis_rx_tdata);
    assign w_in_hdr   = (r_state == RX_HDR);
    assign w_end      = m_axis_rx_tvalid & m_axis_rx_tlast;
    assign w_keep_cnt = popcount8(m_axis_rx_tkeep);
    assign w_len_sum  = {1'b0, r_len} + (m_axis_rx_tlast ? {13'd0, w_keep_cnt} : 17'd8);
    assign w_len      = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

    // DNS flags arrive on beat 5, so a frame ending there is judged on the live beat.
    always_comb begin
        w_hdr = r_hdr;
        if (w_in_hdr && (r_beat == c_HDR_LAST_BEAT)) begin
            w_hdr.beat[5] = w_data_be;
        end
    end

    // IP words: bytes 14-15 on beat 1, 16-31 on beats 2-3, 32-33 on beat 4.
    always_comb begin
        w_csum_add = 4'b0000;
        if (m_axis_rx_tvalid && w_in_hdr) begin
            case (r_beat)
                3'd1:       w_csum_add = 4'b0001;
                3'd2, 3'd3: w_csum_add = 4'b1111;
                3'd4:       w_csum_add = 4'b1000;
                default:    w_csum_add = 4'b0000;
            endcase
        end
    end

    ip_csum_chk u_csum (
        .clk     (clk156),
        .rst_n   (sys_rst_n),
        .i_clr   (w_end),
        .i_add   (w_csum_add),
        .i_words (w_data_be),
        .o_ok    (w_csum_ok)
    );

    assign w_runt    = w_in_hdr && ((r_beat < c_HDR_LAST_BEAT) || (w_keep_cnt < c_RUNT_LAST_BYTES));
    assign w_exp_len = {1'b0, w_hdr.h.ip.tot_len} + c_ETH_HLEN;
    assign w_len_ok  = ({1'b0, w_len} == w_exp_len) ||
                       ((w_exp_len < c_MIN_FRAME) && ({1'b0, w_len} == c_MIN_FRAME));
    assign w_err     = !m_axis_rx_tuser || w_runt || !w_csum_ok || !w_len_ok;
    assign w_match   = !w_err &&
                       (w_hdr.h.eth.ethertype == c_ETHERTYPE_IPV4) &&
                       (w_hdr.h.ip.version == 4'd4) && (w_hdr.h.ip.ihl == 4'd5) &&
                       (w_hdr.h.ip.protocol == c_IPPROTO_UDP) &&
                       (w_hdr.h.ip.daddr == IP_DADDR) &&
                       (w_hdr.h.udp.source == UDP_SPORT) &&
                       (w_hdr.h.udp.dest >= DPORT_LO) && (w_hdr.h.udp.dest <= DPORT_HI) &&
                       w_hdr.h.dns.qr;
    assign w_unused_hdr = ^w_hdr;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= RX_HDR;
            r_beat  <= 3'd0;
            r_len   <= 16'd0;
        end else if (m_axis_rx_tvalid) begin
            if (m_axis_rx_tlast) begin
                r_state <= RX_HDR;
                r_beat  <= 3'd0;
                r_len   <= 16'd0;
            end else begin
                r_len <= w_len;
                if (r_state == RX_HDR) begin
                    if (r_beat == c_HDR_LAST_BEAT) begin
                        r_state <= RX_BODY;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hdr <= '0;
        end else if (m_axis_rx_tvalid && w_in_hdr) begin
            for (int b = 0; b < 6; b++) begin
                if (r_beat == 3'(b)) begin
                    r_hdr.beat[b] <= w_data_be;
                end
            end
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pkt_cnt  <= '0;
            r_dns_cnt  <= '0;
            r_err_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (cnt_clr) begin
            r_pkt_cnt  <= '0;
            r_dns_cnt  <= '0;
            r_err_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_end) begin
            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
            r_byte_cnt <= r_byte_cnt + {32'd0, w_len};
            if (w_match) begin
                r_dns_cnt <= r_dns_cnt + 32'd1;
            end
            if (w_err) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign rx_pkt_cnt  = r_pkt_cnt;
    assign rx_dns_cnt  = r_dns_cnt;
    assign rx_err_cnt  = r_err_cnt;
    assign rx_byte_cnt = r_byte_cnt;

`ifdef ETH_RECV_SUMMARY_EN
    logic        r_pkt_valid;
    logic        r_pkt_ok;
    logic        r_pkt_err;
    logic [31:0] r_pkt_saddr;
    logic [15:0] r_pkt_dport;
    logic [15:0] r_pkt_len;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pkt_valid <= 1'b0;
            r_pkt_ok    <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_pkt_saddr <= '0;
            r_pkt_dport <= '0;
            r_pkt_len   <= '0;
        end else begin
            r_pkt_valid <= w_end;
            if (w_end) begin
                r_pkt_ok    <= w_match;
                r_pkt_err   <= w_err;
                r_pkt_saddr <= w_hdr.h.ip.saddr;
                r_pkt_dport <= w_hdr.h.udp.dest;
                r_pkt_len   <= w_len;
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_ok    = r_pkt_ok;
    assign pkt_err   = r_pkt_err;
    assign pkt_saddr = r_pkt_saddr;
    assign pkt_dport = r_pkt_dport;
    assign pkt_len   = r_pkt_len;
`else
    assign pkt_valid = 1'b0;
    assign pkt_ok    = 1'b0;
    assign pkt_err   = 1'b0;
    assign pkt_saddr = '0;
    assign pkt_dport = '0;
    assign pkt_len   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_recv.sv
//==============================================================================
// tb_eth_recv -- scoreboard testbench for eth_recv (directed frames).
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eth_recv;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic        m_axis_rx_tvalid;
    logic [63:0] m_axis_rx_tdata;
    logic [7:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tuser;
    logic        cnt_clr;
    logic [31:0] rx_pkt_cnt, rx_dns_cnt, rx_err_cnt;
    logic [47:0] rx_byte_cnt;
    logic        pkt_valid, pkt_ok, pkt_err;
    logic [31:0] pkt_saddr;
    logic [15:0] pkt_dport, pkt_len;

    always #3.2 clk156 = ~clk156;

    eth_recv dut (
        .clk156           (clk156),
        .sys_rst_n        (sys_rst_n),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tuser  (m_axis_rx_tuser),
        .cnt_clr          (cnt_clr),
        .rx_pkt_cnt       (rx_pkt_cnt),
        .rx_dns_cnt       (rx_dns_cnt),
        .rx_err_cnt       (rx_err_cnt),
        .rx_byte_cnt      (rx_byte_cnt),
        .pkt_valid        (pkt_valid),
        .pkt_ok           (pkt_ok),
        .pkt_err          (pkt_err),
        .pkt_saddr        (pkt_saddr),
        .pkt_dport        (pkt_dport),
        .pkt_len          (pkt_len)
    );

    typedef struct {
        logic        ok;
        logic        err;
        logic [31:0] saddr;
        logic [15:0] dport;
        logic [15:0] len;
        logic [31:0] pkt;
        logic [31:0] dns;
        logic [31:0] errc;
        logic [47:0] bytes;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] m_pkt, m_dns, m_err;
    logic [47:0] m_bytes;
    logic [7:0]  hdr [0:45];
    logic        r_end_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic build_hdr(input logic [31:0] saddr, input logic [15:0] sport,
                             input logic [15:0] dport, input logic [15:0] tot_len, input bit flip);
        logic [19:0] s;
        logic [16:0] f;
        logic [15:0] ck;
        logic [15:0] ulen;
        hdr[0] = 8'h02; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00; hdr[4] = 8'h00; hdr[5] = 8'h01;
        hdr[6] = 8'h02; hdr[7] = 8'h00; hdr[8] = 8'h00; hdr[9] = 8'h00; hdr[10] = 8'h00; hdr[11] = 8'h02;
        hdr[12] = 8'h08; hdr[13] = 8'h00;
        hdr[14] = 8'h45; hdr[15] = 8'h00; hdr[16] = tot_len[15:8]; hdr[17] = tot_len[7:0];
        hdr[18] = 8'h00; hdr[19] = 8'h00; hdr[20] = 8'h00; hdr[21] = 8'h00;
        hdr[22] = 8'h40; hdr[23] = 8'h11; hdr[24] = 8'h00; hdr[25] = 8'h00;
        hdr[26] = saddr[31:24]; hdr[27] = saddr[23:16]; hdr[28] = saddr[15:8]; hdr[29] = saddr[7:0];
        hdr[30] = 8'h0A; hdr[31] = 8'h00; hdr[32] = 8'h00; hdr[33] = 8'h01;
        s = '0;
        for (int w = 0; w < 10; w++) s = s + {4'h0, hdr[14+2*w], hdr[15+2*w]};
        f  = {1'b0, s[15:0]} + {13'd0, s[19:16]};
        ck = ~(f[15:0] + {15'd0, f[16]});
        hdr[24] = flip ? ~ck[15:8] : ck[15:8];
        hdr[25] = ck[7:0];
        ulen = tot_len - 16'd20;
        hdr[34] = sport[15:8]; hdr[35] = sport[7:0]; hdr[36] = dport[15:8]; hdr[37] = dport[7:0];
        hdr[38] = ulen[15:8];  hdr[39] = ulen[7:0];  hdr[40] = 8'h00; hdr[41] = 8'h00;
        hdr[42] = 8'h12; hdr[43] = 8'h34; hdr[44] = 8'h81; hdr[45] = 8'h80;
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        return (idx < 46) ? hdr[idx] : 8'hA5;
    endfunction

    // Sends beats [first_b, stop_b) of a len-byte frame; stop_b < 0 means through tlast.
    task automatic send_frame(input int len, input int first_b, input int stop_b, input bit tuser_v,
                              input bit clr, input bit gaps, input bit exp_ok, input bit exp_err);
        int   nb, lb, sent;
        exp_t e;
        nb = (len + 7) / 8;
        lb = (stop_b < 0) ? nb : stop_b;
        sent = 0;
        for (int b = first_b; b < lb; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                m_axis_rx_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk156); #1;
                end
            end
            m_axis_rx_tdata = '0;
            m_axis_rx_tkeep = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*b + k < len) begin
                    m_axis_rx_tdata[8*k +: 8] = byte_at(8*b + k);
                    m_axis_rx_tkeep[k] = 1'b1;
                    sent++;
                end
            end
            m_axis_rx_tvalid = 1'b1;
            m_axis_rx_tlast  = (b == nb - 1);
            if (b == nb - 1) begin
                m_axis_rx_tuser = tuser_v;
                cnt_clr = clr;
                e.ok    = exp_ok;
                e.err   = exp_err;
                e.saddr = {hdr[26], hdr[27], hdr[28], hdr[29]};
                e.dport = {hdr[36], hdr[37]};
                e.len   = (sent > 65535) ? 16'hFFFF : 16'(sent);
                if (clr) begin
                    m_pkt = '0; m_dns = '0; m_err = '0; m_bytes = '0;
                end else begin
                    m_pkt   = m_pkt + 32'd1;
                    m_bytes = m_bytes + {32'd0, e.len};
                    if (exp_ok)  m_dns = m_dns + 32'd1;
                    if (exp_err) m_err = m_err + 32'd1;
                end
                e.pkt = m_pkt; e.dns = m_dns; e.errc = m_err; e.bytes = m_bytes;
                sb.push_back(e);
            end
            @(posedge clk156); #1;
        end
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tuser  = 1'b0;
        m_axis_rx_tdata  = '0;
        m_axis_rx_tkeep  = '0;
        cnt_clr = 1'b0;
    endtask

    always @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) r_end_d <= 1'b0;
        else            r_end_d <= m_axis_rx_tvalid & m_axis_rx_tlast;
    end

    always @(negedge clk156) begin
        exp_t e;
        if (sys_rst_n) begin
            if (r_end_d) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_on_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
`ifdef ETH_RECV_SUMMARY_EN
                    chk("pkt_valid", 64'(pkt_valid), 64'd1);
                    chk("pkt_ok", 64'(pkt_ok), 64'(e.ok));
                    chk("pkt_err", 64'(pkt_err), 64'(e.err));
                    chk("pkt_len", 64'(pkt_len), 64'(e.len));
                    if (!e.err) begin
                        chk("pkt_saddr", 64'(pkt_saddr), 64'(e.saddr));
                        chk("pkt_dport", 64'(pkt_dport), 64'(e.dport));
                    end
`else
                    chk("pkt_valid_tied", 64'(pkt_valid), 64'd0);
                    chk("pkt_ok_tied", 64'(pkt_ok), 64'd0);
                    chk("pkt_len_tied", 64'(pkt_len), 64'd0);
`endif
                    chk("rx_pkt_cnt", 64'(rx_pkt_cnt), 64'(e.pkt));
                    chk("rx_dns_cnt", 64'(rx_dns_cnt), 64'(e.dns));
                    chk("rx_err_cnt", 64'(rx_err_cnt), 64'(e.errc));
                    chk("rx_byte_cnt", 64'(rx_byte_cnt), 64'(e.bytes));
                end
            end else if (pkt_valid) begin
                chk("spurious_pkt_valid", 64'(pkt_valid), 64'd0);
            end
        end
    end

    task automatic chk_counters(input string tag, input logic [31:0] p, input logic [31:0] d,
                                input logic [31:0] er, input logic [47:0] by);
        @(negedge clk156);
        chk({tag, "_pkt"}, 64'(rx_pkt_cnt), 64'(p));
        chk({tag, "_dns"}, 64'(rx_dns_cnt), 64'(d));
        chk({tag, "_err"}, 64'(rx_err_cnt), 64'(er));
        chk({tag, "_bytes"}, 64'(rx_byte_cnt), 64'(by));
        @(posedge clk156); #1;
    endtask

    localparam logic [31:0] SADDR = 32'h0A004101;

    initial begin
        sys_rst_n = 1'b0;
        m_axis_rx_tvalid = 1'b0; m_axis_rx_tdata = '0; m_axis_rx_tkeep = '0;
        m_axis_rx_tlast = 1'b0;  m_axis_rx_tuser = 1'b0; cnt_clr = 1'b0;
        m_pkt = '0; m_dns = '0; m_err = '0; m_bytes = '0;
        repeat (4) @(posedge clk156);
        #1 sys_rst_n = 1'b1;
        @(negedge clk156);
        chk("reset_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("reset_pkt_fields", 64'({pkt_ok, pkt_err, pkt_saddr, pkt_len}), 64'd0);
        chk_counters("reset", 32'd0, 32'd0, 32'd0, 48'd0);

        // Good DNS response, 1020 bytes
        build_hdr(SADDR, 16'd53, 16'd50001, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_counters("good", 32'd1, 32'd1, 32'd0, 48'd1020);
        // Bad IP checksum
        build_hdr(SADDR, 16'd53, 16'd50001, 16'd1006, 1'b1);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Port mismatches and range boundaries
        build_hdr(SADDR, 16'd53, 16'd51001, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        build_hdr(SADDR, 16'd54, 16'd50001, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        build_hdr(32'h0A000203, 16'd53, 16'd51000, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        build_hdr(SADDR, 16'd53, 16'd50000, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Runt on beat 3, then a good frame back-to-back
        build_hdr(SADDR, 16'd53, 16'd50001, 16'd1006, 1'b0);
        send_frame(32, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // 46 bytes ends on beat 5 with 6 bytes (ok); 45 bytes is a runt
        build_hdr(SADDR, 16'd53, 16'd50100, 16'd32, 1'b0);
        send_frame(46, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        build_hdr(SADDR, 16'd53, 16'd50100, 16'd31, 1'b0);
        send_frame(45, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Padded minimum frame accepted; 61 bytes for the same tot_len is not
        build_hdr(SADDR, 16'd53, 16'd50200, 16'd32, 1'b0);
        send_frame(60, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(61, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Bad FCS
        build_hdr(SADDR, 16'd53, 16'd50001, 16'd1006, 1'b0);
        send_frame(1020, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Length saturates at 16'hFFFF
        send_frame(65600, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Clear coinciding with a frame end: frame not counted, summary still fires
        build_hdr(SADDR, 16'd53, 16'd50500, 16'd50, 1'b0);
        send_frame(64, 0, -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_counters("clr", 32'd0, 32'd0, 32'd0, 48'd0);
        // 1000 good frames with random gaps
        for (int i = 0; i < 1000; i++) begin
            build_hdr(SADDR + 32'(i), 16'd53, 16'd50001 + 16'(i), 16'd50, 1'b0);
            send_frame(64, 0, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        repeat (2) @(posedge clk156); #1;
        chk_counters("bulk", 32'd1000, 32'd1000, 32'd0, 48'd64000);
        // Reset at beat 60; the tail is parsed as a new, errored frame
        build_hdr(SADDR, 16'd53, 16'd50001, 16'd1006, 1'b0);
        send_frame(1020, 0, 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b0;
        m_pkt = '0; m_dns = '0; m_err = '0; m_bytes = '0;
        repeat (3) @(posedge clk156);
        #1 sys_rst_n = 1'b1;
        chk_counters("midrst", 32'd0, 32'd0, 32'd0, 48'd0);
        send_frame(1020, 60, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(1020, 0, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk156);
        @(negedge clk156);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2ms;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eth_recv.md
# eth_recv

Receive-side companion to the DNS-response flood generator. Sits on the 10G MAC receive AXI-Stream at 156.25 MHz and parses each frame's Ethernet/IPv4/UDP/DNS headers (first 46 bytes). Classifies each frame as a matching DNS response, a non-matching frame or an errored frame. Maintains statistics counters and emits a one-cycle per-frame summary for the rate/coverage monitor.

## Interface
- `ip_daddr`, default 10.0.0.1: required IPv4 destination.
- `udp_sport`, default 53: required UDP source port.
- `dport_lo`, default 50001: lowest accepted UDP destination port.
- `dport_hi`, default 51000: highest accepted UDP destination port.
- `clk156`  in  1  156.25 MHz clock; all logic on rising edge.
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
- `m_axis_rx_tvalid`  in  1  beat valid. No tready: the block always accepts.
- `m_axis_rx_tdata`  in  64  wire byte 0 in [7:0].
- `m_axis_rx_tkeep`  in  8  contiguous from bit 0; not all-ones only on the last beat.
- `m_axis_rx_tlast`  in  1  last beat.
- `m_axis_rx_tuser`  in  1  sampled on the tlast beat; 1 = good FCS.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `rx_pkt_cnt`, `rx_dns_cnt`, `rx_err_cnt`  out  32 each  counts of all frames, matching frames and errored frames.
- `rx_byte_cnt`  out  48  total frame bytes.
- `pkt_valid`  out  1  summary strobe.
- `pkt_ok`  out  1  frame matched.
- `pkt_err`  out  1  frame errored.
- `pkt_saddr`  out  32  IPv4 source address of the frame.
- `pkt_dport`  out  16  UDP destination port of the frame.
- `pkt_len`  out  16  frame byte count.

## Operation
- Header offsets (bytes):
  - Ethernet 0–13; ethertype at 12.
  - IPv4 14–33.
  - UDP 34–41.
  - DNS id/flags 42–45.
  - Header occupies beats 0–5.
- Each header beat is converted with endian_conv64 and overlaid on the packed ethhdr/iphdr/udphdr/dnshdr union.
- States:
  - RX_HDR: beat counter 0..5. Beat 5 without tlast goes to RX_BODY.
  - RX_BODY: waits for tlast, then returns to RX_HDR with beat counter at 0.
  - Reset state: RX_HDR, beat 0.
- IP checksum:
  - Sum the ten 16-bit IP words, including check, as a one's-complement sum with end-around carry.
  - Valid iff the folded result is 16'hFFFF.
- Frame length: 8 bytes per full beat; the last beat adds popcount(tkeep). Saturates at 16'hFFFF.
- Error: any one of the following.
  - tuser=0 on tlast.
  - Runt: tlast before or on beat 4, or on beat 5 with fewer than 6 valid bytes.
  - Bad IP checksum.
  - Frame length ≠ tot_len+14 (frames padded to 60 bytes are accepted when tot_len+14 < 60).
- Match (only if not errored): all of the following.
  - Ethertype 0x0800, version 4, ihl 5, protocol 17.
  - daddr=ip_daddr; sport=udp_sport.
  - dport_lo ≤ dport ≤ dport_hi.
  - DNS qr=1.
- pkt_ok and pkt_err are never both 1.
- Counters:
  - Wrap modulo their width.
  - On a frame end: rx_pkt_cnt+1, rx_byte_cnt+pkt_len, then rx_dns_cnt or rx_err_cnt +1 as classified.
- Reset mid-frame: the tail of the interrupted frame is parsed as a new frame and counted as runt/error. No hang.

## Timing
- Reset: all counters 0; pkt_* outputs 0; state RX_HDR.
- pkt_valid is high exactly one cycle, the cycle after the tlast beat. Summary fields are held until the next pkt_valid.
- Counters update on the same edge that raises pkt_valid.
- Gaps (tvalid=0) may occur anywhere; state and beat counter hold.
- Back-to-back frames (tlast then a new first beat next cycle) are supported at full line rate.
- cnt_clr coinciding with a counter update: clear wins and that frame is not counted. pkt_valid still fires.

## Configuration
- `ETH_RECV_SUMMARY_EN`
  - Defined: pkt_* summary logic is built as above.
  - Undefined: pkt_* are tied to 0, capture registers are removed, and counters are unaffected.

## Structure
- Shared packages:
  - New localparams (header byte offsets, runt/min-frame sizes) go in ethernet_pkg and ip_pkg.
  - rx_state_t goes in ethernet_pkg.
  - Existing header structs and endian_conv64 are reused.
- One sub-module: `ip_csum_chk`, the incremental one's-complement accumulator with clear, add-word and ok output.

## Test plan
- Good DNS response, 1020 bytes (128 beats, last tkeep=8'h0F), saddr 10.0.65.1, dport 50001 → pkt_valid, pkt_ok=1, pkt_len=1020, rx_dns_cnt=1, rx_byte_cnt=1020.
- Same frame with IP check byte flipped → pkt_err=1, rx_err_cnt=1, rx_dns_cnt=0.
- dport 51001 or sport 54, otherwise good → pkt_ok=0, pkt_err=0, rx_pkt_cnt increments only.
- tlast on beat 3 (32 bytes) → runt: pkt_err=1, pkt_len=32. Next good frame back-to-back → pkt_ok=1.
- tuser=0 on tlast of a good frame → pkt_err=1; 1000 good frames with random tvalid gaps → rx_dns_cnt=1000.
- sys_rst_n pulsed low at beat 60, then released → counters 0. Tail frame → rx_err_cnt=1. Following good frame → pkt_ok=1.
